// File: rtl/stdp_update_scheduler_if.sv
// Spike inputs and update-request handshake between an STDP scheduler and its weight engine.
// The scheduler takes the master modport. The weight engine or stimulus takes the slave modport.
interface stdp_update_scheduler_if #(
    parameter int N_SYN = 4,
    parameter int TW    = 16
);
    localparam int SW = (N_SYN > 1) ? $clog2(N_SYN) : 1;

    logic [N_SYN-1:0] pre_spike;
    logic             post_spike;
    logic             upd_ready;
    logic             upd_valid;
    logic [SW-1:0]    upd_syn;
    logic             upd_ltp;
    logic [TW-1:0]    upd_dt;
    logic [N_SYN-1:0] pend;
    logic [7:0]       drop_cnt;
    logic             busy;

    modport master (
        input  pre_spike, post_spike, upd_ready,
        output upd_valid, upd_syn, upd_ltp, upd_dt, pend, drop_cnt, busy
    );

    modport slave (
        output pre_spike, post_spike, upd_ready,
        input  upd_valid, upd_syn, upd_ltp, upd_dt, pend, drop_cnt, busy
    );
endinterface

// File: rtl/stdp_update_scheduler.sv
// STDP pairing detector with one pending slot per synapse, issued round-robin to one update engine.
// Spike to pend takes 1 cycle, and pend to upd_valid takes 1 more. The payload holds until upd_ready, and a re-hit pending slot overwrites it.
module stdp_update_scheduler #(
    parameter int N_SYN  = 4,
    parameter int TW     = 16,
    parameter int WINDOW = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    stdp_update_scheduler_if.master bus
);
    localparam int SW = (N_SYN > 1) ? $clog2(N_SYN) : 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t state, state_nxt;
    logic   load;

    logic [TW-1:0]    pre_t [N_SYN];
    logic [N_SYN-1:0] pre_seen;
    logic [TW-1:0]    post_t;
    logic             post_seen;

    logic [N_SYN-1:0] pend;
    logic [N_SYN-1:0] slot_ltp;
    logic [TW-1:0]    slot_dt [N_SYN];

    logic [N_SYN-1:0] ev, ev_ltp, retire, drop;
    logic [TW-1:0]    ev_dt [N_SYN];
    logic [TW-1:0]    d_post;
    logic             handshake;
    logic [4:0]       drop_inc;
    logic [8:0]       drop_sum;
    logic [7:0]       drop_cnt;
    logic [SW-1:0]    rr_ptr;
    logic [SW-1:0]    sel_idx;
    logic             sel_found;

    // Saturating increment: a saturated timer yields all-ones, which always lies outside the window.
    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
        return (&t) ? t : t + TW'(1);
    endfunction

    assign d_post    = sat_inc(post_t);
    assign handshake = (state == ISSUE) && bus.upd_ready;

    always_comb begin
        ev       = '0;
        ev_ltp   = '0;
        retire   = '0;
        drop     = '0;
        drop_inc = '0;
        for (int i = 0; i < N_SYN; i++) begin
            logic ltp_hit, ltd_hit;
            ltp_hit   = bus.post_spike && !bus.pre_spike[i] && pre_seen[i]
                        && (sat_inc(pre_t[i]) <= TW'(WINDOW));
            ltd_hit   = bus.pre_spike[i] && !bus.post_spike && post_seen
                        && (d_post <= TW'(WINDOW));
            ev[i]     = ltp_hit || ltd_hit;
            ev_ltp[i] = ltp_hit;
            ev_dt[i]  = ltp_hit ? sat_inc(pre_t[i]) : d_post;
            retire[i] = handshake && (bus.upd_syn == SW'(i));
            drop[i]   = ev[i] && pend[i] && !retire[i];
            drop_inc  = drop_inc + 5'(drop[i]);
        end
        drop_sum = 9'(drop_cnt) + 9'(drop_inc);
    end

    // First pending slot at or after rr_ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < N_SYN; k++) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= N_SYN) j = j - N_SYN;
            if (!sel_found && pend[j]) begin
                sel_found = 1'b1;
                sel_idx   = SW'(j);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt = ISSUE;
                    load      = 1'b1;
                end
            end
            ISSUE: begin
                if (bus.upd_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SYN; i++) pre_t[i] <= '0;
            pre_seen  <= '0;
            post_t    <= '0;
            post_seen <= 1'b0;
        end else begin
            for (int i = 0; i < N_SYN; i++) begin
                if (bus.pre_spike[i]) begin
                    pre_t[i]    <= '0;
                    pre_seen[i] <= 1'b1;
                end else begin
                    pre_t[i] <= sat_inc(pre_t[i]);
                end
            end
            if (bus.post_spike) begin
                post_t    <= '0;
                post_seen <= 1'b1;
            end else begin
                post_t <= d_post;
            end
        end
    end

    // A new event wins over retirement, so a slot re-hit during its handshake stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            slot_ltp <= '0;
            for (int i = 0; i < N_SYN; i++) slot_dt[i] <= '0;
            drop_cnt <= '0;
        end else begin
            for (int i = 0; i < N_SYN; i++) begin
                if (ev[i]) begin
                    pend[i]     <= 1'b1;
                    slot_ltp[i] <= ev_ltp[i];
                    slot_dt[i]  <= ev_dt[i];
                end else if (retire[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            drop_cnt <= (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.upd_syn <= '0;
            bus.upd_ltp <= 1'b0;
            bus.upd_dt  <= '0;
            rr_ptr      <= '0;
        end else begin
            if (load) begin
                bus.upd_syn <= sel_idx;
                bus.upd_ltp <= slot_ltp[sel_idx];
                bus.upd_dt  <= slot_dt[sel_idx];
            end
            if (handshake)
                rr_ptr <= (bus.upd_syn == SW'(N_SYN - 1)) ? '0 : bus.upd_syn + SW'(1);
        end
    end

    assign bus.upd_valid = (state == ISSUE);
    assign bus.busy      = (state == ISSUE);
    assign bus.pend      = pend;
    assign bus.drop_cnt  = drop_cnt;

endmodule

// File: tb/tb_stdp_update_scheduler.sv
// Directed bench for stdp_update_scheduler: pairing, window edge, round-robin order, gating, drops, async reset.
module tb_stdp_update_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   vld_cycles = 0;
    int   g_syn[$], g_ltp[$], g_dt[$], g_cyc[$];
    logic stable;

    always #5 clk = ~clk;

    stdp_update_scheduler_if #(.N_SYN(4), .TW(16)) ifc ();

    stdp_update_scheduler #(.N_SYN(4), .TW(16), .WINDOW(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (!rst && ifc.upd_valid) vld_cycles = vld_cycles + 1;
        if (!rst && ifc.upd_valid && ifc.upd_ready) begin
            g_syn.push_back(int'(ifc.upd_syn));
            g_ltp.push_back(int'(ifc.upd_ltp));
            g_dt.push_back(int'(ifc.upd_dt));
            g_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else             n_pass = n_pass + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [3:0] p, input logic q);
        ifc.pre_spike  = p;
        ifc.post_spike = q;
        @(posedge clk);
        #1;
        ifc.pre_spike  = '0;
        ifc.post_spike = 1'b0;
    endtask

    task automatic clr();
        g_syn.delete();
        g_ltp.delete();
        g_dt.delete();
        g_cyc.delete();
        vld_cycles = 0;
    endtask

    task automatic do_reset();
        ifc.pre_spike  = '0;
        ifc.post_spike = 1'b0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        clr();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifc.pre_spike  = '0;
        ifc.post_spike = 1'b0;
        ifc.upd_ready  = 1'b1;
        do_reset();

        check("rst_valid", ifc.upd_valid, 0);
        check("rst_syn",   ifc.upd_syn,   0);
        check("rst_ltp",   ifc.upd_ltp,   0);
        check("rst_dt",    ifc.upd_dt,    0);
        check("rst_pend",  ifc.pend,      0);
        check("rst_drop",  ifc.drop_cnt,  0);
        check("rst_busy",  ifc.busy,      0);

        // Single LTP pairing, separation 5, engine always ready.
        pulse(4'b0100, 1'b0);
        idle(4);
        pulse(4'b0000, 1'b1);
        check("t1_pend_set", ifc.pend, 4'b0100);
        check("t1_vld_lag",  ifc.upd_valid, 0);
        idle(1);
        check("t1_valid", ifc.upd_valid, 1);
        check("t1_busy",  ifc.busy, 1);
        check("t1_syn",   ifc.upd_syn, 2);
        check("t1_ltp",   ifc.upd_ltp, 1);
        check("t1_dt",    ifc.upd_dt, 5);
        idle(1);
        check("t1_vld_off", ifc.upd_valid, 0);
        check("t1_pend_clr", ifc.pend, 0);
        idle(4);
        check("t1_ngrant", g_syn.size(), 1);
        check("t1_vcycles", vld_cycles, 1);
        check("t1_drop", ifc.drop_cnt, 0);

        // LTD exactly at the window edge.
        do_reset();
        pulse(4'b0000, 1'b1);
        idle(63);
        pulse(4'b0010, 1'b0);
        idle(5);
        check("t2_ngrant", g_syn.size(), 1);
        if (g_syn.size() == 1) begin
            check("t2_syn", g_syn[0], 1);
            check("t2_ltp", g_ltp[0], 0);
            check("t2_dt",  g_dt[0], 64);
        end

        // One cycle past the window.
        do_reset();
        pulse(4'b0000, 1'b1);
        idle(64);
        pulse(4'b0010, 1'b0);
        idle(5);
        check("t2_out_ngrant", g_syn.size(), 0);
        check("t2_out_pend", ifc.pend, 0);

        // Round-robin order under an initial stall.
        ifc.upd_ready = 1'b0;
        do_reset();
        pulse(4'b1111, 1'b0);
        idle(2);
        pulse(4'b0000, 1'b1);
        check("t3_pend", ifc.pend, 4'b1111);
        idle(1);
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (!(ifc.upd_valid && ifc.upd_syn == 0 && ifc.upd_ltp && ifc.upd_dt == 3)) stable = 1'b0;
            idle(1);
        end
        check("t3_stall_stable", stable, 1);
        ifc.upd_ready = 1'b1;
        idle(12);
        check("t3_ngrant", g_syn.size(), 4);
        if (g_syn.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("t3_syn%0d", k), g_syn[k], k);
                check($sformatf("t3_dt%0d", k), g_dt[k], 3);
                check($sformatf("t3_ltp%0d", k), g_ltp[k], 1);
            end
            for (int k = 1; k < 4; k++)
                check($sformatf("t3_gap%0d", k), g_cyc[k] - g_cyc[k-1], 2);
        end
        check("t3_drop", ifc.drop_cnt, 0);

        // First-spike gating and simultaneous pre/post.
        do_reset();
        pulse(4'b0000, 1'b1);
        idle(5);
        check("t4_post_only", g_syn.size(), 0);
        pulse(4'b0001, 1'b1);
        idle(5);
        check("t4_simul_ngrant", g_syn.size(), 0);
        check("t4_simul_pend", ifc.pend, 0);

        // Overwrite on synapse 3 while synapse 0 holds the engine.
        ifc.upd_ready = 1'b0;
        do_reset();
        pulse(4'b0000, 1'b1);
        idle(1);
        pulse(4'b0001, 1'b0);
        idle(72);
        pulse(4'b1000, 1'b0);
        idle(2);
        pulse(4'b0000, 1'b1);
        idle(1);
        pulse(4'b0000, 1'b1);
        check("t5_drop", ifc.drop_cnt, 1);
        check("t5_pend", ifc.pend, 4'b1001);
        check("t5_hold_syn", ifc.upd_syn, 0);
        check("t5_hold_dt",  ifc.upd_dt, 2);
        check("t5_hold_ltp", ifc.upd_ltp, 0);
        ifc.upd_ready = 1'b1;
        idle(6);
        check("t5_ngrant", g_syn.size(), 2);
        if (g_syn.size() == 2) begin
            check("t5_g1_syn", g_syn[1], 3);
            check("t5_g1_ltp", g_ltp[1], 1);
            check("t5_g1_dt",  g_dt[1], 5);
        end

        // Drop counter saturation.
        ifc.upd_ready = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (k % 20 == 0) pulse(4'b0000, 1'b1);
            else             pulse(4'b1111, 1'b0);
        end
        check("t6_drop_sat", ifc.drop_cnt, 255);
        check("t6_valid", ifc.upd_valid, 1);

        // Asynchronous reset between clock edges while issuing.
        #2;
        rst = 1'b1;
        #1;
        check("t7_valid", ifc.upd_valid, 0);
        check("t7_pend",  ifc.pend, 0);
        check("t7_busy",  ifc.busy, 0);
        check("t7_drop",  ifc.drop_cnt, 0);
        #2;
        rst = 1'b0;
        clr();
        ifc.upd_ready = 1'b1;
        idle(8);
        check("t7_no_stale", vld_cycles, 0);
        check("t7_pend_after", ifc.pend, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/stdp_update_scheduler.md
# stdp_update_scheduler

Multi-synapse STDP event scheduler. It tracks spike timing for N presynaptic inputs against one postsynaptic neuron and turns each in-window pre/post pairing into an LTP or LTD update request. Pending requests are serialized round-robin onto one shared weight-update engine through a valid/ready handshake. It sits between the spike inputs and the shared weight datapath, so a single update engine can serve every synapse of a neuron.

## Interface
Parameters:
- N_SYN, 4: number of presynaptic inputs (2..16)
- TW, 16: timer and dt width
- WINDOW, 64: largest |dt| (cycles) that produces an update; 1..2^TW-2

Ports:
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- pre_spike  in  N_SYN  one-cycle presynaptic spike pulses, bit i = synapse i
- post_spike  in  1  one-cycle postsynaptic spike pulse
- upd_ready  in  1  update engine accepts the current request
- upd_valid  out  1  request present
- upd_syn  out  max(1,$clog2(N_SYN))  synapse index of the request
- upd_ltp  out  1  1 = potentiate (pre before post), 0 = depress (post before pre)
- upd_dt  out  TW  spike separation in cycles, 1..WINDOW
- pend  out  N_SYN  per-synapse pending-slot flags
- drop_cnt  out  8  count of overwritten pending events, saturates at 255
- busy  out  1  high in the ISSUE state

## Operation
- Timers: per-synapse pre_t[i] and one post_t, each TW bits, with seen flags pre_seen[i] and post_seen.
  - A spike sets the timer to 0 and the seen flag to 1.
  - Otherwise the timer increments and saturates at all-ones.
- Distance: d = timer + 1, saturating. For two spikes k cycles apart, d = k.
- LTP event for synapse i: post_spike=1, pre_spike[i]=0, pre_seen[i]=1, d(pre_t[i]) <= WINDOW. Payload {ltp=1, dt=d(pre_t[i])}.
- LTD event for synapse i: pre_spike[i]=1, post_spike=0, post_seen=1, d(post_t) <= WINDOW. Payload {ltp=0, dt=d(post_t)}.
- Simultaneous pre_spike[i] and post_spike: no event for synapse i (dt=0 ignored); both timers still restart.
- Pending slot, one per synapse, holding {pend, ltp, dt}:
  - An event writes the slot.
  - If the slot is already pending and not being retired that cycle, the new event overwrites it (latest wins) and drop_cnt increments.
- FSM states:
  - IDLE:
    - If any pend, choose the first pending index at or after rr_ptr, wrapping.
    - Load upd_syn/upd_ltp/upd_dt from that slot, assert upd_valid, go to ISSUE.
    - If nothing is pending, stay in IDLE with upd_valid=0.
  - ISSUE:
    - upd_valid=1; the payload is held constant until the handshake.
    - On upd_ready: clear pend[upd_syn], set rr_ptr = upd_syn+1 mod N_SYN, go to IDLE.
    - If a new event hits the same synapse in the handshake cycle, the slot is rewritten and stays pending. This is not counted as a drop.
    - An event on the synapse being issued while not in a handshake cycle overwrites the slot (counted as a drop) but does not change the latched output payload.
- rr_ptr resets to 0.

## Timing
- Reset values: upd_valid=0, upd_syn=0, upd_ltp=0, upd_dt=0, pend=0, drop_cnt=0, busy=0. All timers are 0, all seen flags are 0, FSM is in IDLE.
- A rst assertion mid-handshake drops the request immediately (asynchronous) and empties all slots.
- Event detection to pend set: 1 cycle (registered at the spike edge).
- pend set to upd_valid high: 1 cycle (IDLE registers the selection).
- Handshake completes at the edge where upd_valid && upd_ready. upd_valid is 0 the next cycle.
- Minimum spacing between requests is 2 cycles, so peak throughput is one update per 2 cycles.
- upd_ready while upd_valid=0 is ignored.
- Timers saturate and never wrap. A saturated timer always gives d > WINDOW.

## Test plan
- Single pairing: pre_spike[2] at cycle 10, post_spike at cycle 15, upd_ready tied 1 -> one request with upd_syn=2, upd_ltp=1, upd_dt=5, upd_valid high at cycle 17 for one cycle. pend returns to 0 and drop_cnt stays 0.
- LTD and window edge (WINDOW=64): post at cycle 0, pre_spike[1] at cycle 64 -> request {syn=1, ltp=0, dt=64}. Repeating with a separation of 65 cycles produces no request.
- Round-robin fairness: pre_spike=4'b1111 together, post 3 cycles later, upd_ready held 0 for 5 cycles then 1 -> grants in order syn 0,1,2,3, each with dt=3. Payload stays stable while upd_ready is low.
- Simultaneous spikes and first-spike gating:
  - After reset, post_spike alone produces no request (no pre_seen).
  - pre_spike[0] and post_spike in the same cycle produce no request.
- Overwrite and counter:
  - Hold upd_ready=0 while synapse 3 receives two LTP events -> drop_cnt=1, and the slot holds the newer dt.
  - 300 forced overwrites -> drop_cnt=255.
- Async reset: assert rst mid-ISSUE, between clock edges -> upd_valid, pend and busy go to 0 without waiting for a clock edge. After release, no stale request appears.
